// File: rtl/cpu_pkg.sv
// -----------------------------------------------------------------------------
// cpu_pkg
// Shared CPU definitions: datapath and register-address widths plus the ALU
// function codes driven onto the ALU's ALUFun input.
// No ports (package).
// -----------------------------------------------------------------------------
package cpu_pkg;

  localparam int DW = 32;  // datapath width, equals the ALU operand width
  localparam int RW = 5;   // register-address width

  typedef logic [5:0] alufun_t;

  // Arithmetic
  localparam alufun_t ALU_ADD   = 6'b000000;
  localparam alufun_t ALU_SUB   = 6'b000001;
  // Logic
  localparam alufun_t ALU_AND   = 6'b011000;
  localparam alufun_t ALU_OR    = 6'b011110;
  localparam alufun_t ALU_XOR   = 6'b010110;
  localparam alufun_t ALU_NOR   = 6'b010001;
  localparam alufun_t ALU_PASSA = 6'b011010;
  // Shifts
  localparam alufun_t ALU_SLL   = 6'b100000;
  localparam alufun_t ALU_SRL   = 6'b100001;
  localparam alufun_t ALU_SRA   = 6'b100011;
  // Compares
  localparam alufun_t ALU_EQ    = 6'b110011;
  localparam alufun_t ALU_NEQ   = 6'b110001;
  localparam alufun_t ALU_LT    = 6'b110101;
  localparam alufun_t ALU_LEZ   = 6'b111101;
  localparam alufun_t ALU_LTZ   = 6'b111011;
  localparam alufun_t ALU_GTZ   = 6'b111111;

endpackage

// File: rtl/ex_operand_stage_fwd_sel.sv
// -----------------------------------------------------------------------------
// fwd_sel
// Picks the freshest value of one source register for the EX stage.
// EX/MEM beats MEM/WB; register 0 is never forwarded.
// Ports:
//   i_src_addr                          source register number
//   i_reg_data                          value captured from the register file
//   i_exmem_reg_write/_rd/_result       EX/MEM write-back source
//   i_memwb_reg_write/_rd/_result       MEM/WB write-back source
//   o_data                              selected operand word
// -----------------------------------------------------------------------------
module fwd_sel
  import cpu_pkg::*;
#(
  parameter int DW = cpu_pkg::DW,
  parameter int RW = cpu_pkg::RW
) (
  input  logic [RW-1:0] i_src_addr,
  input  logic [DW-1:0] i_reg_data,
  input  logic          i_exmem_reg_write,
  input  logic [RW-1:0] i_exmem_rd,
  input  logic [DW-1:0] i_exmem_result,
  input  logic          i_memwb_reg_write,
  input  logic [RW-1:0] i_memwb_rd,
  input  logic [DW-1:0] i_memwb_result,
  output logic [DW-1:0] o_data
);

  logic w_hit_exmem;
  logic w_hit_memwb;

  assign w_hit_exmem = i_exmem_reg_write && (i_exmem_rd != '0) && (i_exmem_rd == i_src_addr);
  assign w_hit_memwb = i_memwb_reg_write && (i_memwb_rd != '0) && (i_memwb_rd == i_src_addr);

  always_comb begin
    o_data = i_reg_data;
    if (w_hit_exmem) begin
      o_data = i_exmem_result;
    end else if (w_hit_memwb) begin
      o_data = i_memwb_result;
    end
  end

endmodule

// File: rtl/ex_operand_stage.sv
// -----------------------------------------------------------------------------
// ex_operand_stage
// ID/EX pipeline register plus EX operand selection for the ALU (A, B, ALUFun,
// Sign). Detects load-use hazards and inserts bubbles on hazard or flush.
//
// Build option: macro EX_FWD_EN.
//   defined   - EX/MEM and MEM/WB results are forwarded into both operands;
//               hazard_stall covers load-use only.
//   undefined - operands come straight from the captured register data;
//               hazard_stall additionally fires on any ID source that matches
//               a pending write in EX or EX/MEM.
//
// Ports:
//   clk, reset (sync, active-high), stall (freeze), flush (load bubble)
//   id_*            decoded fields of the instruction in ID
//   exmem_*, memwb_* write-back sources used for forwarding
//   alu_a, alu_b, alufun, sign   ALU inputs
//   ex_rd, ex_reg_write, ex_mem_read, ex_mem_write, ex_store_data, ex_valid
//   hazard_stall    combinational request for ID/IF to hold
// -----------------------------------------------------------------------------
module ex_operand_stage
  import cpu_pkg::*;
#(
  parameter int DW = cpu_pkg::DW,
  parameter int RW = cpu_pkg::RW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          stall,
  input  logic          flush,
  input  logic          id_valid,
  input  logic [RW-1:0] id_rs_addr,
  input  logic [RW-1:0] id_rt_addr,
  input  logic [RW-1:0] id_rd_addr,
  input  logic [DW-1:0] id_rs_data,
  input  logic [DW-1:0] id_rt_data,
  input  logic [DW-1:0] id_imm,
  input  logic [4:0]    id_shamt,
  input  logic          id_src_a_shamt,
  input  logic          id_src_b_imm,
  input  logic [5:0]    id_alufun,
  input  logic          id_sign,
  input  logic          id_reg_write,
  input  logic          id_mem_read,
  input  logic          id_mem_write,
  input  logic          exmem_reg_write,
  input  logic [RW-1:0] exmem_rd,
  input  logic [DW-1:0] exmem_result,
  input  logic          memwb_reg_write,
  input  logic [RW-1:0] memwb_rd,
  input  logic [DW-1:0] memwb_result,
  output logic [DW-1:0] alu_a,
  output logic [DW-1:0] alu_b,
  output logic [5:0]    alufun,
  output logic          sign,
  output logic [RW-1:0] ex_rd,
  output logic          ex_reg_write,
  output logic          ex_mem_read,
  output logic          ex_mem_write,
  output logic [DW-1:0] ex_store_data,
  output logic          ex_valid,
  output logic          hazard_stall
);

  // ID/EX register
  logic          r_valid;
  logic [RW-1:0] r_rs_addr;
  logic [RW-1:0] r_rt_addr;
  logic [RW-1:0] r_rd;
  logic [DW-1:0] r_rs_data;
  logic [DW-1:0] r_rt_data;
  logic [DW-1:0] r_imm;
  logic [4:0]    r_shamt;
  logic          r_src_a_shamt;
  logic          r_src_b_imm;
  alufun_t       r_alufun;
  logic          r_sign;
  logic          r_reg_write;
  logic          r_mem_read;
  logic          r_mem_write;

  logic          w_bubble;
  logic          w_ex_match;
  logic          w_load_use;
  logic [DW-1:0] w_fwd_rs;
  logic [DW-1:0] w_fwd_rt;

  // EX destination matches either ID source (register 0 is a constant).
  assign w_ex_match = (r_rd != '0) && ((r_rd == id_rs_addr) || (r_rd == id_rt_addr));
  assign w_load_use = id_valid && r_valid && r_mem_read && w_ex_match;

`ifdef EX_FWD_EN
  assign hazard_stall = w_load_use;

  fwd_sel #(.DW(DW), .RW(RW)) u_fwd_rs (
    .i_src_addr        (r_rs_addr),
    .i_reg_data        (r_rs_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_data            (w_fwd_rs)
  );

  fwd_sel #(.DW(DW), .RW(RW)) u_fwd_rt (
    .i_src_addr        (r_rt_addr),
    .i_reg_data        (r_rt_data),
    .i_exmem_reg_write (exmem_reg_write),
    .i_exmem_rd        (exmem_rd),
    .i_exmem_result    (exmem_result),
    .i_memwb_reg_write (memwb_reg_write),
    .i_memwb_rd        (memwb_rd),
    .i_memwb_result    (memwb_result),
    .o_data            (w_fwd_rt)
  );
`else
  // Without forwarding, any in-flight write the register file has not yet
  // absorbed must be waited out. MEM/WB is safe: the file writes before it reads.
  logic w_exmem_match;
  logic w_unused;

  assign w_exmem_match = (exmem_rd != '0) &&
                         ((exmem_rd == id_rs_addr) || (exmem_rd == id_rt_addr));
  assign hazard_stall  = w_load_use ||
                         (id_valid && ((r_valid && r_reg_write && w_ex_match) ||
                                       (exmem_reg_write && w_exmem_match)));

  assign w_fwd_rs = r_rs_data;
  assign w_fwd_rt = r_rt_data;

  // Inputs and fields only the forwarding path consumes.
  assign w_unused = ^{exmem_result, memwb_reg_write, memwb_rd, memwb_result,
                      r_rs_addr, r_rt_addr};
`endif

  // An empty ID slot is captured as a bubble so held data stays clean.
  assign w_bubble = flush || hazard_stall || !id_valid;

  always_ff @(posedge clk) begin
    if (reset || (!stall && w_bubble)) begin
      r_valid       <= 1'b0;
      r_rs_addr     <= '0;
      r_rt_addr     <= '0;
      r_rd          <= '0;
      r_rs_data     <= '0;
      r_rt_data     <= '0;
      r_imm         <= '0;
      r_shamt       <= '0;
      r_src_a_shamt <= 1'b0;
      r_src_b_imm   <= 1'b0;
      r_alufun      <= ALU_ADD;
      r_sign        <= 1'b0;
      r_reg_write   <= 1'b0;
      r_mem_read    <= 1'b0;
      r_mem_write   <= 1'b0;
    end else if (!stall) begin
      r_valid       <= 1'b1;
      r_rs_addr     <= id_rs_addr;
      r_rt_addr     <= id_rt_addr;
      r_rd          <= id_rd_addr;
      r_rs_data     <= id_rs_data;
      r_rt_data     <= id_rt_data;
      r_imm         <= id_imm;
      r_shamt       <= id_shamt;
      r_src_a_shamt <= id_src_a_shamt;
      r_src_b_imm   <= id_src_b_imm;
      r_alufun      <= id_alufun;
      r_sign        <= id_sign;
      r_reg_write   <= id_reg_write;
      r_mem_read    <= id_mem_read;
      r_mem_write   <= id_mem_write;
    end
  end

  assign alu_a         = r_src_a_shamt ? {{(DW-5){1'b0}}, r_shamt} : w_fwd_rs;
  assign alu_b         = r_src_b_imm ? r_imm : w_fwd_rt;
  assign ex_store_data = w_fwd_rt;
  assign alufun        = r_alufun;
  assign sign          = r_sign;
  assign ex_rd         = r_rd;
  assign ex_valid      = r_valid;
  assign ex_reg_write  = r_valid && r_reg_write;
  assign ex_mem_read   = r_valid && r_mem_read;
  assign ex_mem_write  = r_valid && r_mem_write;

endmodule

// File: tb/tb_ex_operand_stage.sv
module tb_ex_operand_stage;

  logic        clk = 1'b0;
  logic        reset, stall, flush, id_valid;
  logic [4:0]  id_rs_addr, id_rt_addr, id_rd_addr, id_shamt;
  logic [31:0] id_rs_data, id_rt_data, id_imm;
  logic        id_src_a_shamt, id_src_b_imm, id_sign;
  logic [5:0]  id_alufun;
  logic        id_reg_write, id_mem_read, id_mem_write;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd, memwb_rd;
  logic [31:0] exmem_result, memwb_result;
  logic [31:0] alu_a, alu_b, ex_store_data;
  logic [5:0]  alufun;
  logic        sign, ex_reg_write, ex_mem_read, ex_mem_write, ex_valid, hazard_stall;
  logic [4:0]  ex_rd;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  ex_operand_stage dut (
    .clk(clk), .reset(reset), .stall(stall), .flush(flush), .id_valid(id_valid),
    .id_rs_addr(id_rs_addr), .id_rt_addr(id_rt_addr), .id_rd_addr(id_rd_addr),
    .id_rs_data(id_rs_data), .id_rt_data(id_rt_data), .id_imm(id_imm),
    .id_shamt(id_shamt), .id_src_a_shamt(id_src_a_shamt), .id_src_b_imm(id_src_b_imm),
    .id_alufun(id_alufun), .id_sign(id_sign), .id_reg_write(id_reg_write),
    .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
    .exmem_reg_write(exmem_reg_write), .exmem_rd(exmem_rd), .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd(memwb_rd), .memwb_result(memwb_result),
    .alu_a(alu_a), .alu_b(alu_b), .alufun(alufun), .sign(sign), .ex_rd(ex_rd),
    .ex_reg_write(ex_reg_write), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_store_data(ex_store_data), .ex_valid(ex_valid), .hazard_stall(hazard_stall)
  );

  typedef struct {
    string       nm;
    logic        v;
    logic [4:0]  rs, rt, rd, shamt;
    logic [31:0] rs_d, rt_d, imm;
    logic        sa, sb;
    logic [5:0]  fun;
    logic        sgn, rw, mr, mw;
    logic        xw;
    logic [4:0]  xrd;
    logic [31:0] xres;
    logic        ww;
    logic [4:0]  wrd;
    logic [31:0] wres;
    logic [31:0] ea, eb, est;        // expected with forwarding
    logic [31:0] ea_nf, eb_nf, est_nf; // expected without forwarding
  } vec_t;

  vec_t vecs[10];
  vec_t exp_q[$];

  function automatic vec_t mk(string nm, logic v, logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
      logic [31:0] rs_d, logic [31:0] rt_d, logic [31:0] imm, logic [4:0] shamt, logic sa, logic sb,
      logic [5:0] fun, logic sgn, logic rw, logic mr, logic mw,
      logic xw, logic [4:0] xrd, logic [31:0] xres, logic ww, logic [4:0] wrd, logic [31:0] wres,
      logic [31:0] ea, logic [31:0] eb, logic [31:0] est,
      logic [31:0] ea_nf, logic [31:0] eb_nf, logic [31:0] est_nf);
    vec_t t;
    t.nm = nm; t.v = v; t.rs = rs; t.rt = rt; t.rd = rd; t.rs_d = rs_d; t.rt_d = rt_d;
    t.imm = imm; t.shamt = shamt; t.sa = sa; t.sb = sb; t.fun = fun; t.sgn = sgn;
    t.rw = rw; t.mr = mr; t.mw = mw; t.xw = xw; t.xrd = xrd; t.xres = xres;
    t.ww = ww; t.wrd = wrd; t.wres = wres; t.ea = ea; t.eb = eb; t.est = est;
    t.ea_nf = ea_nf; t.eb_nf = eb_nf; t.est_nf = est_nf;
    return t;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic fwd_off();
    exmem_reg_write = 1'b0; exmem_rd = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd = '0; memwb_result = '0;
  endtask

  task automatic drive_id(input vec_t t);
    id_valid = t.v; id_rs_addr = t.rs; id_rt_addr = t.rt; id_rd_addr = t.rd;
    id_rs_data = t.rs_d; id_rt_data = t.rt_d; id_imm = t.imm; id_shamt = t.shamt;
    id_src_a_shamt = t.sa; id_src_b_imm = t.sb; id_alufun = t.fun; id_sign = t.sgn;
    id_reg_write = t.rw; id_mem_read = t.mr; id_mem_write = t.mw;
  endtask

  task automatic drive_fwd(input vec_t t);
    exmem_reg_write = t.xw; exmem_rd = t.xrd; exmem_result = t.xres;
    memwb_reg_write = t.ww; memwb_rd = t.wrd; memwb_result = t.wres;
  endtask

  // Simple ID instruction with no forwarding data attached.
  function automatic vec_t instr(logic [4:0] rs, logic [4:0] rt, logic [4:0] rd,
      logic [31:0] rs_d, logic [31:0] rt_d, logic [5:0] fun, logic rw, logic mr);
    return mk("seq", 1, rs, rt, rd, rs_d, rt_d, 0, 0, 0, 0, fun, 0, rw, mr, 0,
              0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endfunction

  vec_t idle;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t t, e;
    logic [31:0] xa, xb, xs;

    //        name         v rs rt rd rs_d   rt_d    imm     sh sa sb fun        sg rw mr mw  xw xrd xres     ww wrd wres    ea      eb      est      ea_nf   eb_nf   est_nf
    vecs[0] = mk("fwd_exmem", 1, 1, 2, 3, 32'hA, 32'hB, 0, 0, 0, 0, 6'b000000, 0, 1, 0, 0, 1, 1, 32'h11, 1, 1, 32'h22, 32'h11, 32'hB, 32'hB, 32'hA, 32'hB, 32'hB);
    vecs[1] = mk("fwd_memwb", 1, 1, 2, 3, 32'hA, 32'hB, 0, 0, 0, 0, 6'b000000, 0, 1, 0, 0, 1, 4, 32'h11, 1, 1, 32'h22, 32'h22, 32'hB, 32'hB, 32'hA, 32'hB, 32'hB);
    vecs[2] = mk("zero_reg",  1, 0, 0, 3, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 1, 0, 0, 1, 0, 32'hFFFF, 1, 0, 32'h77, 0, 0, 0, 0, 0, 0);
    vecs[3] = mk("shift_sll", 1, 0, 1, 4, 0, 32'h1, 0, 4, 1, 0, 6'b100000, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h4, 32'h1, 32'h1, 32'h4, 32'h1, 32'h1);
    vecs[4] = mk("imm_b",     1, 2, 2, 5, 32'h10, 32'h20, 32'h1234, 0, 0, 1, 6'b011110, 0, 1, 0, 0, 0, 0, 0, 1, 2, 32'h55, 32'h55, 32'h1234, 32'h55, 32'h10, 32'h1234, 32'h20);
    vecs[5] = mk("sub_sign",  1, 6, 7, 8, 100, 3, 0, 0, 0, 0, 6'b000001, 1, 1, 0, 0, 1, 7, 32'h99, 1, 6, 32'h66, 32'h66, 32'h99, 32'h99, 100, 3, 3);
    vecs[6] = mk("store",     1, 9, 10, 0, 32'h1000, 32'hCAFE, 8, 0, 0, 1, 6'b000000, 0, 0, 0, 1, 1, 10, 32'hBEEF, 0, 0, 0, 32'h1000, 8, 32'hBEEF, 32'h1000, 8, 32'hCAFE);
    vecs[7] = mk("load",      1, 12, 0, 11, 32'h2000, 0, 4, 0, 0, 1, 6'b000000, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 32'h2000, 4, 0, 32'h2000, 4, 0);
    vecs[8] = mk("invalid",   0, 3, 3, 13, 32'h9, 32'h9, 5, 7, 0, 0, 6'b000001, 1, 1, 1, 1, 1, 0, 32'h44, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[9] = mk("same_rs_rt",1, 14, 14, 15, 32'h5, 32'h6, 0, 0, 0, 0, 6'b010110, 0, 1, 0, 0, 1, 14, 32'hDEAD, 1, 14, 32'h1, 32'hDEAD, 32'hDEAD, 32'hDEAD, 32'h5, 32'h6, 32'h6);
    idle = mk("idle", 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6'b000000, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // Reset state
    reset = 1; stall = 0; flush = 0;
    drive_id(idle); fwd_off();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_valid", ex_valid, 0);
    chk("rst_alufun", alufun, 0);
    chk("rst_alu_a", alu_a, 0);
    chk("rst_alu_b", alu_b, 0);
    chk("rst_ctrl", {ex_reg_write, ex_mem_read, ex_mem_write, sign}, 0);
    chk("rst_hazard", hazard_stall, 0);
    @(negedge clk) reset = 0;

    // Table: capture one instruction, then present forwarding sources and compare.
    foreach (vecs[i]) begin
      @(negedge clk);
      drive_id(vecs[i]); fwd_off();
      exp_q.push_back(vecs[i]);
      @(negedge clk);
      drive_fwd(vecs[i]); id_valid = 1'b0;
      #1;
      if (exp_q.size() == 0) begin
        chk({vecs[i].nm, "_scoreboard"}, 0, 1);
      end else begin
        e = exp_q.pop_front();
`ifdef EX_FWD_EN
        xa = e.ea; xb = e.eb; xs = e.est;
`else
        xa = e.ea_nf; xb = e.eb_nf; xs = e.est_nf;
`endif
        chk({e.nm, "_alu_a"}, alu_a, xa);
        chk({e.nm, "_alu_b"}, alu_b, xb);
        chk({e.nm, "_store"}, ex_store_data, xs);
        chk({e.nm, "_alufun"}, alufun, e.v ? e.fun : 6'b0);
        chk({e.nm, "_sign"}, sign, e.v & e.sgn);
        chk({e.nm, "_valid"}, ex_valid, e.v);
        chk({e.nm, "_rd"}, ex_rd, e.v ? e.rd : 5'd0);
        chk({e.nm, "_ctrl"}, {ex_reg_write, ex_mem_read, ex_mem_write},
            {e.v & e.rw, e.v & e.mr, e.v & e.mw});
        chk({e.nm, "_hazard"}, hazard_stall, 0);
        $display("vector %s: a=0x%0h b=0x%0h fun=%b", e.nm, alu_a, alu_b, alufun);
      end
    end
    @(negedge clk);
    fwd_off();

    // Reset with a valid instruction in EX
    @(negedge clk) drive_id(instr(1, 2, 3, 5, 7, 6'b000000, 1, 0));
    @(posedge clk); #1;
    chk("seq_add_a", alu_a, 5);
    @(negedge clk) reset = 1;
    @(posedge clk); #1;
    chk("seq_rst_valid", ex_valid, 0);
    chk("seq_rst_fun", alufun, 0);
    chk("seq_rst_ab", {alu_a, alu_b} != 0, 0);
    @(negedge clk) begin reset = 0; drive_id(idle); end

    // Load-use: lw r5 then add r6,r5,r2
    @(negedge clk) drive_id(instr(0, 0, 5, 0, 0, 6'b000000, 1, 1));
    @(negedge clk) drive_id(instr(5, 2, 6, 32'h100, 32'h200, 6'b000000, 1, 0));
    #1;
    chk("lu_hazard", hazard_stall, 1);
    @(posedge clk); #1;
    chk("lu_bubble_valid", ex_valid, 0);
    chk("lu_hazard_drop", hazard_stall, 0);
    @(posedge clk); #1;
    chk("lu_add_valid", ex_valid, 1);
    chk("lu_add_rd", ex_rd, 6);
    chk("lu_add_a", alu_a, 32'h100);
    chk("lu_add_b", alu_b, 32'h200);
    $display("sequence load_use: add issued after one bubble");
    @(negedge clk) drive_id(idle);

    // Hazard together with stall: state held, request stays up
    @(negedge clk) drive_id(instr(0, 0, 5, 0, 0, 6'b000000, 1, 1));
    @(negedge clk) begin drive_id(instr(5, 0, 6, 1, 2, 6'b000000, 1, 0)); stall = 1; end
    @(posedge clk); #1;
    chk("hs_valid", ex_valid, 1);
    chk("hs_mem_read", ex_mem_read, 1);
    chk("hs_rd", ex_rd, 5);
    chk("hs_hazard", hazard_stall, 1);
    @(negedge clk) stall = 0;
    @(posedge clk); #1;
    chk("hs_bubble", ex_valid, 0);
    @(negedge clk) drive_id(idle);

    // Reset while a load-use hazard is pending
    @(negedge clk) drive_id(instr(0, 0, 5, 0, 0, 6'b000000, 1, 1));
    @(negedge clk) drive_id(instr(0, 5, 7, 0, 0, 6'b000000, 1, 0));
    #1;
    chk("rh_hazard", hazard_stall, 1);
    reset = 1;
    @(posedge clk); #1;
    chk("rh_hazard_drop", hazard_stall, 0);
    chk("rh_valid", ex_valid, 0);
    @(negedge clk) begin reset = 0; drive_id(idle); end

    // Stall and flush together, then flush alone
    @(negedge clk) drive_id(instr(3, 4, 10, 32'h33, 32'h44, 6'b010110, 1, 0));
    @(posedge clk); #1;
    chk("sf_load_a", alu_a, 32'h33);
    @(negedge clk) begin drive_id(instr(0, 0, 12, 32'h77, 0, 6'b011110, 1, 0)); stall = 1; flush = 1; end
    @(posedge clk); #1;
    chk("sf_hold_valid", ex_valid, 1);
    chk("sf_hold_rd", ex_rd, 10);
    chk("sf_hold_fun", alufun, 6'b010110);
    chk("sf_hold_a", alu_a, 32'h33);
    chk("sf_hold_b", alu_b, 32'h44);
    chk("sf_hold_rw", ex_reg_write, 1);
    @(negedge clk) stall = 0;
    @(posedge clk); #1;
    chk("sf_bubble_valid", ex_valid, 0);
    chk("sf_bubble_fun", alufun, 0);
    chk("sf_bubble_rw", ex_reg_write, 0);
    chk("sf_bubble_rd", ex_rd, 0);
    $display("sequence stall_flush: held then bubbled");
    @(negedge clk) begin flush = 0; drive_id(idle); end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
